display_scanout: RTL



---
 rtl/display_scanout.sv | 94 +++++++++
 1 files changed

// File: rtl/display_scanout.sv
// display_scanout: VGA-class raster timing with 2x-replicated RGB565 framebuffer scan-out and per-frame render trigger
module display_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SCALE      = 2,
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 240,
  parameter int RD_LATENCY = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  output logic [$clog2(FB_WIDTH*FB_HEIGHT)-1:0]  fb_rd_addr,
  input  logic [15:0]                            fb_rd_data,
  input  logic                                   frame_done,
  output logic                                   frame_start,
  output logic [23:0]                            rgb,
  output logic                                   hsync,
  output logic                                   vsync,
  output logic                                   de,
  output logic [7:0]                             dropped_frames
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = $clog2(FB_WIDTH*FB_HEIGHT);
  localparam int SH = $clog2(SCALE);
  localparam int DL = 1 + RD_LATENCY;
  localparam logic [HW-1:0] HA  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS0 = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS1 = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] HL  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VA  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS0 = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS1 = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] VL  = VW'(V_TOTAL - 1);
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          active, hs_n, vs_n, trig;
  logic [AW-1:0] addr;
  logic [DL-1:0] de_d, hs_d, vs_d;
  logic [4:0]    r5, b5;
  logic [5:0]    g6;
  always_comb begin
    active = (hcount < HA) && (vcount < VA);
    hs_n   = !((hcount >= HS0) && (hcount < HS1));
    vs_n   = !((vcount >= VS0) && (vcount < VS1));
    trig   = (hcount == '0) && (vcount == VA);
    addr   = AW'(hcount >> SH) + AW'(FB_WIDTH) * AW'(vcount >> SH);
    r5     = fb_rd_data[15:11];
    g6     = fb_rd_data[10:5];
    b5     = fb_rd_data[4:0];
  end
  assign frame_start = !rst && trig && frame_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= (hcount == HL) ? '0 : hcount + 1'b1;
      vcount <= (hcount != HL) ? vcount : (vcount == VL) ? '0 : vcount + 1'b1;
    end
  end
  // sync/de ride a delay line matched to address register + RAM latency + output register
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_rd_addr     <= '0;
      de_d           <= '0;
      hs_d           <= '1;
      vs_d           <= '1;
      rgb            <= '0;
      de             <= 1'b0;
      hsync          <= 1'b1;
      vsync          <= 1'b1;
      dropped_frames <= '0;
    end else begin
      fb_rd_addr     <= active ? addr : '0;
      de_d           <= {de_d[DL-2:0], active};
      hs_d           <= {hs_d[DL-2:0], hs_n};
      vs_d           <= {vs_d[DL-2:0], vs_n};
      de             <= de_d[DL-1];
      hsync          <= hs_d[DL-1];
      vsync          <= vs_d[DL-1];
      rgb            <= de_d[DL-1] ? {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]} : '0;
      dropped_frames <= (trig && !frame_done && dropped_frames != 8'hFF) ? dropped_frames + 8'd1 : dropped_frames;
    end
  end
endmodule
